// File: rtl/dmem_if.sv
// dmem_if: core request/response port and word-memory bus of dmem_access_ctrl.
// The slave modport is the controller's view; master is the core/memory side.
interface dmem_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  mem_re;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [3:0]            mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_re, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_re, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: byte/half/word load-store sequencer onto a word-organised data memory.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; otherwise they return resp_err.
module dmem_access_ctrl #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              f3_q, f3_d;
  logic [DM_ADDRESS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rbuf_q, rbuf_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    cross_q;
  logic                    split_q;
  logic                    err_cur;
  logic [3:0]              size_mask;
  logic [7:0]              strb_wide;
  logic [2*DATA_W-1:0]     data_wide;
  logic [4:0]              lane_sh;
  logic [DM_ADDRESS-3:0]   word0, word1;
  logic [DATA_W-1:0]       beat_lo, beat_hi, asm_word, rdata_cur;

  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   cross_q = 1'b0;
      2'b01:   cross_q = (addr_q[1:0] == 2'b11);
      default: cross_q = (addr_q[1:0] != 2'b00);
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  assign split_q = cross_q;
  assign err_cur = 1'b0;
`else
  assign split_q = 1'b0;
  assign err_cur = cross_q;
`endif

  // Store lanes: the low nibble/word of the widened shift is beat 0, the high part is beat 1.
  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign lane_sh   = {addr_q[1:0], 3'b000};
  assign strb_wide = {4'b0000, size_mask} << addr_q[1:0];
  assign data_wide = {{DATA_W{1'b0}}, wdata_q} << lane_sh;
  assign word0     = addr_q[DM_ADDRESS-1:2];
  assign word1     = word0 + {{(DM_ADDRESS-3){1'b0}}, 1'b1};

  // Load assembly: beat 0 comes from the BEAT1 capture on split loads, otherwise live.
  assign beat_lo  = split_q ? rbuf_q : bus.mem_rdata;
  assign beat_hi  = split_q ? bus.mem_rdata : '0;
  assign asm_word = DATA_W'({beat_hi, beat_lo} >> lane_sh);

  always_comb begin
    rdata_cur = '0;
    if (!we_q && !err_cur) begin
      unique case (f3_q[1:0])
        2'b00:   rdata_cur = {{24{~f3_q[2] & asm_word[7]}}, asm_word[7:0]};
        2'b01:   rdata_cur = {{16{~f3_q[2] & asm_word[15]}}, asm_word[15:0]};
        default: rdata_cur = asm_word;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A rejected crossing access still spends the BEAT0 slot (strobes suppressed) so its
  // response lands with the same latency as a single-beat access.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = BEAT0;
      BEAT0:   state_d = split_q ? BEAT1 : DONE;
      BEAT1:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    bus.resp_rdata = (state_q == DONE) ? rdata_cur : rdata_q;
    bus.resp_err   = (state_q == DONE) ? err_cur : err_q;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wstrb  = '0;
    if (state_q == BEAT0 && !err_cur) begin
      bus.mem_re   = ~we_q;
      bus.mem_we   = we_q;
      bus.mem_addr = {word0, 2'b00};
      if (we_q) begin
        bus.mem_wdata = data_wide[DATA_W-1:0];
        bus.mem_wstrb = strb_wide[3:0];
      end
    end else if (state_q == BEAT1) begin
      bus.mem_re   = ~we_q;
      bus.mem_we   = we_q;
      bus.mem_addr = {word1, 2'b00};
      if (we_q) begin
        bus.mem_wdata = data_wide[2*DATA_W-1:DATA_W];
        bus.mem_wstrb = strb_wide[7:4];
      end
    end
  end

  always_comb begin
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && bus.req_valid) begin
      we_d    = bus.req_we;
      f3_d    = bus.req_funct3;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end
    if (state_q == BEAT1) rbuf_d = bus.mem_rdata;
    if (state_q == DONE) begin
      rdata_d = rdata_cur;
      err_d   = err_cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 128-word byte-strobed memory model.
// Expectations follow MISALIGN_SPLIT_EN the same way the design does.
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();
  dmem_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [128] = '{default: '0};
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wstrb[i]) mem[bus.mem_addr[8:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    if (bus.mem_re) rd_q <= mem[bus.mem_addr[8:2]];
  end
  assign bus.mem_rdata = rd_q;

  int n_tests = 0;
  int n_fail  = 0;

  int          nbeats, lat;
  logic [31:0] b_addr [2];
  logic [31:0] b_strb [2];
  logic [31:0] b_wdata[2];
  logic        b_we   [2];
  logic [31:0] r_rdata;
  logic        r_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                      input logic [31:0] wd);
    int waitc = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    while (!bus.req_ready && waitc < 8) begin
      tick();
      waitc++;
    end
    chk("ready_before_accept", {31'b0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    nbeats  = 0;
    lat     = 0;
    r_rdata = 'x;
    r_err   = 1'bx;
    for (int c = 1; c <= 6; c++) begin
      if (bus.mem_re || bus.mem_we) begin
        chk("re_we_exclusive", {31'b0, bus.mem_re & bus.mem_we}, 32'd0);
        if (nbeats < 2) begin
          b_addr[nbeats]  = {23'b0, bus.mem_addr};
          b_strb[nbeats]  = {28'b0, bus.mem_wstrb};
          b_wdata[nbeats] = bus.mem_wdata;
          b_we[nbeats]    = bus.mem_we;
        end
        nbeats++;
      end
      if (bus.resp_valid) begin
        lat     = c;
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic exp_resp(input string tag, input int beats, input int l,
                          input logic [31:0] rdata, input logic err);
    chk({tag, ".beats"}, nbeats, beats);
    chk({tag, ".latency"}, lat, l);
    chk({tag, ".rdata"}, r_rdata, rdata);
    chk({tag, ".err"}, {31'b0, r_err}, {31'b0, err});
  endtask

  task automatic exp_beat(input string tag, input int i, input logic we, input logic [8:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    chk({tag, ".addr"}, b_addr[i], {23'b0, a});
    chk({tag, ".we"}, {31'b0, b_we[i]}, {31'b0, we});
    if (we) begin
      chk({tag, ".strb"}, b_strb[i], {28'b0, s});
      chk({tag, ".wdata"}, b_wdata[i], d);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    chk({tag, ".resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    chk({tag, ".resp_err"}, {31'b0, bus.resp_err}, 32'd0);
    chk({tag, ".resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, ".mem_re"}, {31'b0, bus.mem_re}, 32'd0);
    chk({tag, ".mem_we"}, {31'b0, bus.mem_we}, 32'd0);
    chk({tag, ".mem_addr"}, {23'b0, bus.mem_addr}, 32'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, ".mem_wstrb"}, {28'b0, bus.mem_wstrb}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    tick(); tick(); tick();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // aligned word store and load
    xact(1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    exp_resp("sw010", 1, 2, 32'h0, 1'b0);
    exp_beat("sw010", 0, 1'b1, 9'h010, 4'hF, 32'hDEADBEEF);
    xact(1'b0, 3'b010, 9'h010, 32'h0);
    exp_resp("lw010", 1, 2, 32'hDEADBEEF, 1'b0);
    exp_beat("lw010", 0, 1'b0, 9'h010, 4'h0, 32'h0);
    chk("rdata_hold", bus.resp_rdata, 32'hDEADBEEF);

    // byte and halfword extension
    xact(1'b1, 3'b010, 9'h020, 32'h80FF7F01);
    exp_resp("sw020", 1, 2, 32'h0, 1'b0);
    xact(1'b0, 3'b000, 9'h023, 32'h0);
    exp_resp("lb023", 1, 2, 32'hFFFFFF80, 1'b0);
    xact(1'b0, 3'b100, 9'h023, 32'h0);
    exp_resp("lbu023", 1, 2, 32'h00000080, 1'b0);
    xact(1'b0, 3'b000, 9'h021, 32'h0);
    exp_resp("lb021", 1, 2, 32'h0000007F, 1'b0);
    xact(1'b0, 3'b001, 9'h022, 32'h0);
    exp_resp("lh022", 1, 2, 32'hFFFF80FF, 1'b0);
    xact(1'b0, 3'b101, 9'h020, 32'h0);
    exp_resp("lhu020", 1, 2, 32'h00007F01, 1'b0);
    xact(1'b0, 3'b111, 9'h020, 32'h0);
    exp_resp("lw_f3_111", 1, 2, 32'h80FF7F01, 1'b0);

    // sub-word stores in place
    xact(1'b1, 3'b000, 9'h031, 32'h123456AB);
    exp_resp("sb031", 1, 2, 32'h0, 1'b0);
    exp_beat("sb031", 0, 1'b1, 9'h030, 4'b0010, 32'h3456AB00);
    xact(1'b0, 3'b010, 9'h030, 32'h0);
    exp_resp("lw030", 1, 2, 32'h0000AB00, 1'b0);
    xact(1'b1, 3'b001, 9'h006, 32'h0000A55A);
    exp_resp("sh006", 1, 2, 32'h0, 1'b0);
    exp_beat("sh006", 0, 1'b1, 9'h004, 4'b1100, 32'hA55A0000);
    xact(1'b0, 3'b001, 9'h006, 32'h0);
    exp_resp("lh006", 1, 2, 32'hFFFFA55A, 1'b0);

`ifdef MISALIGN_SPLIT_EN
    xact(1'b1, 3'b001, 9'h007, 32'h0000A55A);
    exp_resp("sh007", 2, 3, 32'h0, 1'b0);
    exp_beat("sh007.b0", 0, 1'b1, 9'h004, 4'b1000, 32'h5A000000);
    exp_beat("sh007.b1", 1, 1'b1, 9'h008, 4'b0001, 32'h000000A5);
    xact(1'b0, 3'b101, 9'h007, 32'h0);
    exp_resp("lhu007", 2, 3, 32'h0000A55A, 1'b0);
    exp_beat("lhu007.b0", 0, 1'b0, 9'h004, 4'h0, 32'h0);
    exp_beat("lhu007.b1", 1, 1'b0, 9'h008, 4'h0, 32'h0);
    xact(1'b1, 3'b010, 9'h1FE, 32'h11223344);
    exp_resp("sw1fe", 2, 3, 32'h0, 1'b0);
    exp_beat("sw1fe.b0", 0, 1'b1, 9'h1FC, 4'b1100, 32'h33440000);
    exp_beat("sw1fe.b1", 1, 1'b1, 9'h000, 4'b0011, 32'h00001122);
    xact(1'b0, 3'b010, 9'h1FE, 32'h0);
    exp_resp("lw1fe", 2, 3, 32'h11223344, 1'b0);
    xact(1'b0, 3'b001, 9'h1FF, 32'h0);
    exp_resp("lh1ff", 2, 3, 32'h00002233, 1'b0);
`else
    xact(1'b0, 3'b010, 9'h002, 32'h0);
    exp_resp("lw002", 0, 2, 32'h0, 1'b1);
    chk("err_hold", {31'b0, bus.resp_err}, 32'd1);
    xact(1'b1, 3'b001, 9'h007, 32'h0000A55A);
    exp_resp("sh007", 0, 2, 32'h0, 1'b1);
    xact(1'b0, 3'b001, 9'h006, 32'h0);
    exp_resp("lh006_after_err", 1, 2, 32'hFFFFA55A, 1'b0);
`endif

    // request held high while busy is taken again only after DONE
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 9'h010;
    bus.req_wdata  = '0;
    chk("hold.ready_idle", {31'b0, bus.req_ready}, 32'd1);
    tick();
    chk("hold.ready_beat0", {31'b0, bus.req_ready}, 32'd0);
    chk("hold.re_beat0", {31'b0, bus.mem_re}, 32'd1);
    tick();
    chk("hold.ready_done", {31'b0, bus.req_ready}, 32'd0);
    chk("hold.resp_done", {31'b0, bus.resp_valid}, 32'd1);
    chk("hold.re_done", {31'b0, bus.mem_re}, 32'd0);
    tick();
    chk("hold.ready_idle2", {31'b0, bus.req_ready}, 32'd1);
    chk("hold.resp_idle2", {31'b0, bus.resp_valid}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("hold.re_second", {31'b0, bus.mem_re}, 32'd1);
    chk("hold.addr_second", {23'b0, bus.mem_addr}, 32'h010);
    tick();
    chk("hold.resp_second", {31'b0, bus.resp_valid}, 32'd1);
    chk("hold.rdata_second", bus.resp_rdata, 32'hDEADBEEF);
    tick();

    // reset during an in-flight store
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_wdata  = 32'hCAFEF00D;
`ifdef MISALIGN_SPLIT_EN
    bus.req_addr   = 9'h0F2;
    tick();
    bus.req_valid = 1'b0;
    chk("rst.we_beat0", {31'b0, bus.mem_we}, 32'd1);
    tick();
    chk("rst.addr_beat1", {23'b0, bus.mem_addr}, 32'h0F4);
`else
    bus.req_addr   = 9'h0F0;
    tick();
    bus.req_valid = 1'b0;
    chk("rst.we_beat0", {31'b0, bus.mem_we}, 32'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst.no_resp1", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst.ready1", {31'b0, bus.req_ready}, 32'd1);
    tick();
    chk("rst.no_resp2", {31'b0, bus.resp_valid}, 32'd0);
`ifdef MISALIGN_SPLIT_EN
    xact(1'b0, 3'b010, 9'h0F0, 32'h0);
    exp_resp("rst.lw0f0", 1, 2, 32'hF00D0000, 1'b0);
    xact(1'b0, 3'b010, 9'h0F4, 32'h0);
    exp_resp("rst.lw0f4", 1, 2, 32'h0, 1'b0);
`else
    xact(1'b0, 3'b010, 9'h0F0, 32'h0);
    exp_resp("rst.lw0f0", 1, 2, 32'h0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
